// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer, one second per ten clk ticks.
// Optional: define COUNTDOWN_TIMER_AUTO_RELOAD_EN for auto-reload on expiry.
module countdown_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       LD_timer,
    input  logic       START,
    input  logic       PAUSE,
    input  logic       STOP_al,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0,
    output logic       timer_out,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        EXPIRED
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [15:0] disp_d;
    logic        tmo_d;
    logic        load_ok;
    logic        time_zero;
    logic        count_en;
    logic [15:0] disp_q;
    logic [15:0] dec;
    logic [15:0] din;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    logic [15:0] reload_q;
`endif

    assign disp_q    = {M_out1, M_out0, S_out1, S_out0};
    assign din       = {M_in1, M_in0, S_in1, S_in0};
    assign time_zero = (disp_q == 16'h0000);
    assign running   = (state_q == RUN);

    assign load_ok = LD_timer
                   && (M_in1 <= 4'd9) && (M_in0 <= 4'd9)
                   && (S_in1 <= 4'd5) && (S_in0 <= 4'd9);

    // One-second BCD decrement with borrow ripple; only used when non-zero.
    always_comb begin
        dec = disp_q;
        if (S_out0 != 4'd0) begin
            dec[3:0] = S_out0 - 4'd1;
        end else begin
            dec[3:0] = 4'd9;
            if (S_out1 != 4'd0) begin
                dec[7:4] = S_out1 - 4'd1;
            end else begin
                dec[7:4] = 4'd5;
                if (M_out0 != 4'd0) begin
                    dec[11:8] = M_out0 - 4'd1;
                end else begin
                    dec[11:8]  = 4'd9;
                    dec[15:12] = M_out1 - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        disp_d   = disp_q;
        tmo_d    = timer_out;
        count_en = 1'b0;

        if (LD_timer) begin
            // An invalid load swallows the cycle without touching anything.
            if (load_ok) begin
                disp_d  = din;
                tick_d  = 4'd0;
                tmo_d   = 1'b0;
                state_d = IDLE;
            end
        end else if (STOP_al && state_q == EXPIRED) begin
            tmo_d   = 1'b0;
            state_d = IDLE;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        end else if (STOP_al && state_q == RUN) begin
            tmo_d    = 1'b0;
            count_en = 1'b1;
`endif
        end else if (PAUSE) begin
            if (state_q == RUN) begin
                state_d = HOLD;
            end
        end else if (START && (state_q == IDLE || state_q == HOLD)) begin
            if (!time_zero) begin
                state_d = RUN;
            end
        end else if (state_q == RUN) begin
            count_en = 1'b1;
        end

        if (count_en) begin
            if (tick_q == 4'd9) begin
                tick_d = 4'd0;
                if (!time_zero) begin
                    disp_d = dec;
                end
                if (dec == 16'h0000) begin
                    tmo_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                    disp_d = reload_q;
`else
                    state_d = EXPIRED;
`endif
                end
            end else begin
                tick_d = tick_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tick_q    <= 4'd0;
            M_out1    <= 4'd0;
            M_out0    <= 4'd0;
            S_out1    <= 4'd0;
            S_out0    <= 4'd0;
            timer_out <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            M_out1    <= disp_d[15:12];
            M_out0    <= disp_d[11:8];
            S_out1    <= disp_d[7:4];
            S_out0    <= disp_d[3:0];
            timer_out <= tmo_d;
        end
    end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q <= 16'h0000;
        end else if (load_ok) begin
            reload_q <= din;
        end
    end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus
// multi-cycle sequences, expected values queued and popped per edge.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] M_in1, M_in0, S_in1, S_in0;
    logic       LD_timer, START, PAUSE, STOP_al;
    logic [3:0] M_out1, M_out0, S_out1, S_out0;
    logic       timer_out, running;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        st;
        logic        pa;
        logic        sp;
        logic [15:0] din;
        logic [15:0] dout;
        logic        tmo;
        logic        run;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        t;
        logic        r;
        string       nm;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[16];

    countdown_timer dut (
        .clk       (clk),
        .reset     (reset),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .S_in1     (S_in1),
        .S_in0     (S_in0),
        .LD_timer  (LD_timer),
        .START     (START),
        .PAUSE     (PAUSE),
        .STOP_al   (STOP_al),
        .M_out1    (M_out1),
        .M_out0    (M_out0),
        .S_out1    (S_out1),
        .S_out0    (S_out0),
        .timer_out (timer_out),
        .running   (running)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        logic [15:0] got;
        e   = sb.pop_front();
        got = {M_out1, M_out0, S_out1, S_out0};
        checks++;
        if (got !== e.d || timer_out !== e.t || running !== e.r) begin
            errors++;
            $display("FAIL %s: got %h t=%b r=%b, expected %h t=%b r=%b",
                     e.nm, got, timer_out, running, e.d, e.t, e.r);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        reset    = v.rst;
        LD_timer = v.ld;
        START    = v.st;
        PAUSE    = v.pa;
        STOP_al  = v.sp;
        {M_in1, M_in0, S_in1, S_in0} = v.din;
        sb.push_back('{v.dout, v.tmo, v.run, nm});
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic cyc(input logic ld, input logic st, input logic pa,
                       input logic sp, input logic [15:0] din,
                       input logic [15:0] dout, input logic tmo,
                       input logic run, input string nm);
        vec_t v;
        v = '{1'b0, ld, st, pa, sp, din, dout, tmo, run};
        apply(v, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        LD_timer = 1'b0; START = 1'b0; PAUSE = 1'b0; STOP_al = 1'b0;
        {M_in1, M_in0, S_in1, S_in0} = 16'h0000;

        //          rst   ld    st    pa    sp    din       dout      tmo   run
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0660, 16'h1234, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hA000, 16'h1234, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0530, 16'h0530, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0530, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0530, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0530, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0009, 16'h0009, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0009, 1'b0, 1'b1};

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

`ifndef COUNTDOWN_TIMER_AUTO_RELOAD_EN
        // 00:03 counts down to expiry, then stays latched until STOP_al.
        cyc(1, 0, 0, 0, 16'h0003, 16'h0003, 0, 0, "exp_load");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0003, 0, 1, "exp_start");
        for (int k = 1; k <= 30; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, 16'(3 - k / 10),
                k == 30, k < 30, $sformatf("exp_t%0d", k));
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, "exp_hold");
        end
        cyc(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, "exp_stop");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, "exp_restart0");
`else
        // Auto-reload: 00:02 reloads at expiry and keeps running.
        cyc(1, 0, 0, 0, 16'h0002, 16'h0002, 0, 0, "ar_load");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0002, 0, 1, "ar_start");
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0, 0, 16'h0000,
                (k == 20) ? 16'h0002 : 16'(2 - k / 10),
                k == 20, 1, $sformatf("ar_t%0d", k));
        end
        cyc(0, 0, 0, 1, 16'h0000, 16'h0002, 0, 1, "ar_stop");
`endif

        // Full borrow chain 10:00 -> 09:59.
        cyc(1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, "bor_load");
        cyc(0, 1, 0, 0, 16'h0000, 16'h1000, 0, 1, "bor_start");
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, (k == 10) ? 16'h0959 : 16'h1000,
                0, 1, $sformatf("bor_t%0d", k));
        end

        // Pause keeps the partial tick count across the hold.
        cyc(1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, "pz_load");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0100, 0, 1, "pz_start");
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, 16'h0100, 0, 1, "pz_run");
        end
        cyc(0, 0, 1, 0, 16'h0000, 16'h0100, 0, 0, "pz_pause");
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 0, 1, 16'h0000, 16'h0100, 0, 0, "pz_hold");
        end
        cyc(0, 1, 0, 0, 16'h0000, 16'h0100, 0, 1, "pz_resume");
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, (k == 5) ? 16'h0059 : 16'h0100,
                0, 1, $sformatf("pz_t%0d", k));
        end

        // Load coinciding with the expiring decrement wins; ticks restart.
        cyc(1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, "lw_load");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0001, 0, 1, "lw_start");
        for (int k = 0; k < 9; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, 16'h0001, 0, 1, "lw_run");
        end
        cyc(1, 0, 0, 0, 16'h0007, 16'h0007, 0, 0, "lw_reload");
        cyc(0, 1, 0, 0, 16'h0000, 16'h0007, 0, 1, "lw_start2");
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0, 16'h0000, (k == 10) ? 16'h0006 : 16'h0007,
                0, 1, $sformatf("lw_t%0d", k));
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
